// File: rtl/receptor_pkg.sv
// Shared types and defaults for the pulse-burst receiver.
package receptor_pkg;

  // Default count width and idle gap (in clk cycles) that closes a burst.
  localparam int unsigned CNT_W_DEF        = 4;
  localparam int unsigned IDLE_TIMEOUT_DEF = 16;

  // Idle timer width; IDLE_TIMEOUT must stay within 2..255 to fit.
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser bringing the asynchronous pulse line into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Double-register the input; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/receptor_pulsos.sv
// Counts rising edges of a gated pulse train, groups them into bursts closed by an
// idle gap, and holds the result until the consumer acknowledges it.
module receptor_pulsos
  import receptor_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             overflow,
  output logic             lost
);

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(IDLE_TIMEOUT - 1);

  logic               s2;
  logic               s3;
  logic [2:0]         vld;
  logic               flanco;
  estado_t            estado;
  logic [TIMER_W-1:0] timer;

  sincronizador u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     (pulse_in),
    .q     (s2)
  );

  // Third copy for edge detection, plus a record of how many stages hold real samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3  <= 1'b0;
      vld <= '0;
    end else begin
      s3  <= s2;
      vld <= {vld[1:0], 1'b1};
    end
  end

  // Until s3 carries a post-reset sample its zero is only the reset value, so a line
  // held high through reset must not be mistaken for a rise.
  assign flanco = s2 & ~s3 & vld[2];

  // Burst FSM with counter, idle timer and status flags, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      count    <= '0;
      timer    <= '0;
      overflow <= 1'b0;
      lost     <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (flanco) begin
            estado <= COUNT;
            count  <= CNT_W'(1);
            timer  <= '0;
            busy   <= 1'b1;
          end
        end
        COUNT: begin
          if (flanco) begin
            // An edge always wins over a timeout landing in the same cycle.
            timer <= '0;
            if (count == CNT_MAX) begin
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            estado <= DONE;
            busy   <= 1'b0;
            valid  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // Edges here are dropped, including on the ack cycle.
          if (flanco) begin
            lost <= 1'b1;
          end
          if (ack) begin
            estado   <= IDLE;
            valid    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            timer    <= '0;
          end
        end
        default: begin
          estado   <= IDLE;
          count    <= '0;
          timer    <= '0;
          overflow <= 1'b0;
          valid    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/receptor_pulsos.md
RECEPTOR_PULSOS -- requirements
Module: receptor_pulsos

Interface
REQ-001 SHALL have parameter CNT_W, default 4, count width in bits.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16, idle clock cycles that close a burst; legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pulse_in  input  1  gated pulse train from the trigger line; asynchronous to clk.
REQ-006 SHALL have port ack  input  1  consumer acknowledges the reported burst.
REQ-007 SHALL have port count  output  CNT_W  number of rising edges in the last completed burst.
REQ-008 SHALL have port valid  output  1  count holds a completed burst.
REQ-009 SHALL have port busy  output  1  burst in progress.
REQ-010 SHALL have port overflow  output  1  burst exceeded 2^CNT_W-1 edges; count saturated.
REQ-011 SHALL have port lost  output  1  sticky; an edge arrived while in DONE.

Function
REQ-012 SHALL synchronise pulse_in through two flip-flops, then detect rising edges against a third registered copy: edge = s2 & ~s3.
REQ-013 SHALL reflect a pulse_in rise in count/busy on the third rising clk edge after the rise is sampled; pulse_in high and low phases are each at least 2 clk cycles.
REQ-014 SHALL implement FSM states IDLE, COUNT and DONE.
REQ-015 IDLE: count=0, valid=0, busy=0; an edge moves the FSM to COUNT with count=1 and the idle timer cleared.
REQ-016 COUNT: busy=1; each edge increments count and clears the timer; no edge increments the timer.
REQ-017 COUNT saturation: an edge with count=2^CNT_W-1 holds count and sets overflow.
REQ-018 COUNT timeout: timer reaching IDLE_TIMEOUT-1 with no edge moves the FSM to DONE; valid asserts exactly IDLE_TIMEOUT cycles after the last counted edge.
REQ-019 COUNT edge-vs-timeout: an edge in the same cycle as timer=IDLE_TIMEOUT-1 is counted and the FSM stays in COUNT.
REQ-020 DONE: valid=1, busy=0; count and overflow are held stable until ack.
REQ-021 DONE ack: ack=1 moves the FSM to IDLE next cycle, with count=0 and overflow=0 that cycle; ack outside DONE is ignored.
REQ-022 DONE edge: an edge in DONE, including the ack cycle, is dropped and sets lost; it does not start a new burst.
REQ-023 lost SHALL clear only on reset.
REQ-024 Timer width SHALL be 8 bits; the timer does not wrap while in COUNT.

Reset
REQ-025 reset=1 at a clk edge SHALL force IDLE, count=0, valid=0, busy=0, overflow=0, lost=0, timer=0 and all synchroniser flops=0, with priority over all other inputs.
REQ-026 Reset mid-burst or in DONE SHALL discard the burst; the first edge after reset is counted only if pulse_in rises after reset is released.

Structure
REQ-027 A shared package receptor_pkg SHALL hold the state enum (IDLE, COUNT, DONE), the default CNT_W and IDLE_TIMEOUT, and the timer width constant.
REQ-028 The synchroniser SHALL be the sub-module sincronizador: 2 flops, synchronous active-high reset.
REQ-029 FSM, counter, timer and flags SHALL reside in receptor_pulsos.

Verification
REQ-030 Single burst: 2 pulses (4 clk high/4 low) -> busy, then valid=1 with count=2 exactly 16 cycles after the second edge; ack -> IDLE, count=0.
REQ-031 Saturation: 20 pulses, CNT_W=4 -> count=15, overflow=1, valid=1; ack clears overflow.
REQ-032 Gap boundary: inter-edge gap of 15 cycles -> one burst of 2; gap of 17 cycles -> first burst closes with count=1.
REQ-033 Edge in DONE: pulse while valid=1, no ack -> count unchanged, lost=1, no new busy; after ack, the next pulse gives count=1.
REQ-034 Reset mid-burst: 3 edges, then reset 1 cycle -> all outputs 0 and IDLE; the next burst of 1 pulse reports count=1.
REQ-035 Ack without valid: ack=1 in IDLE and COUNT -> no state or output change.
